mobo_mem_responder: RTL and testbench



---
 rtl/mobo_mem_responder.sv | 197 +++++++++++++++++++
 tb/tb_mobo_mem_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mobo_mem_responder.sv
// mobo_mem_responder: motherboard-side responder for the CPU memory bus.
// It decodes CPU requests, inserts WAIT_CYCLES wait states, and serves
// reads and writes from an internal word-addressed RAM. The response uses a
// four-phase req/ack handshake.
//
// Ports
//   clk        clock; all state changes on posedge
//   rst        asynchronous, active-low reset
//   mobo_ctrl  CPU control: bit0 req, bit1 we (1 write, 0 read); other bits ignored
//   addr       word address from the CPU (full width is decoded, no aliasing)
//   data_out   CPU write data
//   mobo_stat  status: bit0 ack, bit1 busy, bit2 err; other bits always 0
//   data_in    read data returned to the CPU
//
// Optional build macro: MOBO_TRACE_EN. When it is defined, every access edge
// prints a transaction line with a cycle count since reset. Ports and cycle
// behaviour are the same in both builds.
module mobo_mem_responder #(
  parameter int unsigned word_width  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [word_width-1:0] mobo_ctrl,
  input  logic [word_width-1:0] addr,
  input  logic [word_width-1:0] data_out,
  output logic [word_width-1:0] mobo_stat,
  output logic [word_width-1:0] data_in
);

  localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [word_width-1:0] addr_q, addr_d;
  logic [word_width-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  rel_q, rel_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [word_width-1:0] data_in_d;

  logic                  req_c;
  logic                  acc_c;
  logic                  in_range_c;
  logic                  mem_wr_c;
  logic [word_width-1:0] rd_word_c;

  logic [word_width-1:0] mem [MEM_DEPTH];

  // Only req and we are decoded; the remaining control bits are reduced here
  // purely so they are visibly consumed.
  logic unused_ctrl;
  assign unused_ctrl = ^mobo_ctrl[word_width-1:2];

  assign req_c      = mobo_ctrl[0];
  assign acc_c      = (state_q == WAIT) && (cnt_q == '0);
  assign in_range_c = (addr_q < word_width'(MEM_DEPTH));
  assign rd_word_c  = mem[addr_q[AW-1:0]];

  assign mobo_stat = {{(word_width-3){1'b0}}, err_q, busy_q, ack_q};

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rel_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_in <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rel_q   <= rel_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      data_in <= data_in_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rel_d     = rel_q;
    ack_d     = ack_q;
    busy_d    = busy_q;
    err_d     = err_q;
    data_in_d = data_in;
    mem_wr_c  = 1'b0;

    case (state_q)
      IDLE: begin
        ack_d  = 1'b0;
        busy_d = 1'b0;
        if (req_c) begin
          addr_d  = addr;
          wdata_d = data_out;
          we_d    = mobo_ctrl[1];
          cnt_d   = CW'(WAIT_CYCLES);
          rel_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // Remember an early release so ACK lasts exactly one cycle even if
        // req is raised again before the ACK edge.
        rel_d = rel_q | ~req_c;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (in_range_c) begin
            err_d = 1'b0;
            if (we_q) begin
              mem_wr_c = 1'b1;
            end else begin
              data_in_d = rd_word_c;
            end
          end else begin
            err_d     = 1'b1;
            data_in_d = '0;
          end
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
        end
      end

      ACK: begin
        if (!req_c || rel_q) begin
          ack_d   = 1'b0;
          err_d   = 1'b0;
          rel_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // RAM write port; contents survive reset. A reset during WAIT returns the
  // FSM to IDLE at once, so mem_wr_c can never fire for an aborted access.
  always_ff @(posedge clk) begin
    if (mem_wr_c) begin
      mem[addr_q[AW-1:0]] <= wdata_q;
    end
  end

`ifdef MOBO_TRACE_EN
  logic [31:0] cyc_q;

  // Cycle counter since reset plus one trace line per access edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (acc_c) begin
        $display("mobo_mem_responder: %s addr=%h data=%h err=%0d cycle=%0d",
                 we_q ? "W" : "R", addr_q,
                 we_q ? wdata_q : (in_range_c ? rd_word_c : '0),
                 !in_range_c, cyc_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mobo_mem_responder.sv
// Testbench for mobo_mem_responder: instance 0 uses WAIT_CYCLES=2, instance 1
// uses WAIT_CYCLES=0. Expected responses are pushed to a scoreboard queue when
// a request is driven and popped when the DUT raises ack.
module tb_mobo_mem_responder;

  typedef struct {
    logic [31:0] stat;
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] ctrl   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wdat   [2];
  logic [31:0] stat   [2];
  logic [31:0] din    [2];

  logic [31:0] model   [2][256];
  logic [31:0] last_rd [2];
  exp_t        sb[$];

  int n_cmp;
  int n_err;

  mobo_mem_responder #(.word_width(32), .MEM_DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mobo_ctrl (ctrl[0]),
    .addr      (addr_s[0]),
    .data_out  (wdat[0]),
    .mobo_stat (stat[0]),
    .data_in   (din[0])
  );

  mobo_mem_responder #(.word_width(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .mobo_ctrl (ctrl[1]),
    .addr      (addr_s[1]),
    .data_out  (wdat[1]),
    .mobo_stat (stat[1]),
    .data_in   (din[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full handshake on instance k. early=1 drops req right after S.
  // Inputs are scrambled after S to show the latched values are used.
  task automatic xfer(input int k, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input bit early, input logic [31:0] stray);
    exp_t e;
    exp_t got;
    int   n;
    bit   busy_bad;
    bit   err;
    err = (a >= 32'd256);
    if (err)      e.data = 32'h0;
    else if (we)  e.data = last_rd[k];
    else          e.data = model[k][a[7:0]];
    e.stat = {29'h0, err, 1'b0, 1'b1};
    e.lat  = (k == 0) ? 3 : 1;
    sb.push_back(e);
    if (we && !err) model[k][a[7:0]] = d;
    last_rd[k] = e.data;

    @(negedge clk);
    ctrl[k]   = (stray & ~32'h3) | {30'h0, we, 1'b1};
    addr_s[k] = a;
    wdat[k]   = d;
    @(posedge clk);  // sampling edge S
    @(negedge clk);
    addr_s[k] = ~a;
    wdat[k]   = ~d;
    ctrl[k]   = (stray & ~32'h3) | {30'h0, ~we, ~early};
    busy_bad  = (stat[k] !== 32'h2);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      #1;
      if (stat[k][0] === 1'b1) break;
      if (stat[k] !== 32'h2) busy_bad = 1'b1;
    end
    chk($sformatf("latency[%0d] a=%h", k, a), 32'(n), 32'(e.lat));
    chk($sformatf("busy[%0d] a=%h", k, a), {31'h0, busy_bad}, 32'h0);
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'h1, 32'h0);
    end else begin
      got = sb.pop_front();
      chk($sformatf("stat[%0d] a=%h", k, a), stat[k], got.stat);
      chk($sformatf("data_in[%0d] a=%h", k, a), din[k], got.data);
    end
    if (early) begin
      @(posedge clk);
      #1;
      chk($sformatf("ack pulse[%0d] a=%h", k, a), stat[k], 32'h0);
    end else begin
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("ack hold[%0d] a=%h", k, a), stat[k], e.stat);
      @(negedge clk);
      ctrl[k] = 32'h0;
      @(posedge clk);
      #1;
      chk($sformatf("release[%0d] a=%h", k, a), stat[k], 32'h0);
    end
    chk($sformatf("data keep[%0d] a=%h", k, a), din[k], e.data);
    @(negedge clk);
    ctrl[k] = 32'h0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ctrl[k]    = 32'h0;
      addr_s[k]  = 32'h0;
      wdat[k]    = 32'h0;
      last_rd[k] = 32'h0;
    end

    // Reset held for 3 cycles, then idle with req=0.
    repeat (3) @(negedge clk);
    chk("reset stat", stat[0], 32'h0);
    chk("reset data_in", din[0], 32'h0);
    chk("reset stat w0", stat[1], 32'h0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle stat %0d", i), stat[0], 32'h0);
    end
    chk("idle data_in", din[0], 32'h0);

    // Write then read back.
    xfer(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'd5, 32'h0, 1'b0, 32'h0);

    // Out-of-range accesses; high address bits must not alias.
    xfer(0, 1'b1, 32'd44, 32'h44444444, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'd256, 32'h0, 1'b0, 32'h0);
    xfer(0, 1'b1, 32'd300, 32'd7, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'd44, 32'h0, 1'b0, 32'h0);
    xfer(0, 1'b0, 32'h8000_0005, 32'h0, 1'b0, 32'h0);

    // Early release of req still completes the write.
    xfer(0, 1'b1, 32'd9, 32'h1234, 1'b1, 32'h0);
    xfer(0, 1'b0, 32'd9, 32'h0, 1'b0, 32'h0);

    // Reset during WAIT aborts the pending write.
    xfer(0, 1'b1, 32'd3, 32'h55, 1'b0, 32'h0);
    @(negedge clk);
    ctrl[0]   = 32'h3;
    addr_s[0] = 32'd3;
    wdat[0]   = 32'hAA;
    @(posedge clk);
    @(negedge clk);
    chk("mid busy", stat[0], 32'h2);
    rst = 1'b0;
    #1;
    chk("mid reset stat", stat[0], 32'h0);
    chk("mid reset data_in", din[0], 32'h0);
    last_rd[0] = 32'h0;
    last_rd[1] = 32'h0;
    repeat (2) @(negedge clk);
    ctrl[0] = 32'h0;
    rst     = 1'b1;
    xfer(0, 1'b0, 32'd3, 32'h0, 1'b0, 32'h0);

    // Zero-wait instance with stray control bits set.
    xfer(1, 1'b1, 32'd0, 32'hCAFEF00D, 1'b0, 32'hFFFF_FFFC);
    xfer(1, 1'b0, 32'd0, 32'h0, 1'b0, 32'hFFFF_FFFC);
    xfer(1, 1'b1, 32'd255, 32'h0BAD_F00D, 1'b1, 32'h0);
    xfer(1, 1'b0, 32'd255, 32'h0, 1'b1, 32'hA5A5_A5A4);
    xfer(1, 1'b0, 32'd256, 32'h0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
